// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multiplies retire three edges after issue; dividers run a 32-step radix-2 restoring loop.
module md_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MDOp,
    input  logic        ex_adv,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        isbusy
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [31:0] mag_a_r, mag_a_s;
    logic [31:0] mag_b_r, mag_b_s;
    logic [31:0] a_orig_r, a_orig_s;
    logic        neg_res_r, neg_res_s;
    logic        neg_rem_r, neg_rem_s;
    logic        div_zero_r, div_zero_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;

    logic        sgn_op_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [63:0] prod_s;
    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        q_bit_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;

    // Operand sign decode, product and one restoring-division step.
    always_comb begin
        sgn_op_s   = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_neg_s    = sgn_op_s & A[31];
        b_neg_s    = sgn_op_s & B[31];
        prod_s     = cneg64({32'd0, mag_a_r} * {32'd0, mag_b_r}, neg_res_r);
        shifted_s  = {rem_r, quo_r[31]};
        diff_s     = shifted_s - {1'b0, mag_b_r};
        q_bit_s    = ~diff_s[32];
        rem_step_s = q_bit_s ? diff_s[31:0] : shifted_s[31:0];
        quo_step_s = {quo_r[30:0], q_bit_s};
    end

    // Stall request: busy while an operation runs or one is being issued.
    always_comb begin
        isbusy = (state_r != ST_IDLE) |
                 (ex_adv & ~flush & (MDOp >= OP_MULT) & (MDOp <= OP_DIVU));
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        mag_a_s    = mag_a_r;
        mag_b_s    = mag_b_r;
        a_orig_s   = a_orig_r;
        neg_res_s  = neg_res_r;
        neg_rem_s  = neg_rem_r;
        div_zero_s = div_zero_r;
        rem_s      = rem_r;
        quo_s      = quo_r;

        if (flush) begin
            // Cancel outranks both completion and a new issue.
            state_s = ST_IDLE;
            cnt_s   = 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_adv) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                state_s   = ST_MUL;
                                cnt_s     = 5'd2;
                                mag_a_s   = cneg32(A, a_neg_s);
                                mag_b_s   = cneg32(B, b_neg_s);
                                neg_res_s = a_neg_s ^ b_neg_s;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_s    = ST_DIV;
                                cnt_s      = 5'd31;
                                mag_a_s    = cneg32(A, a_neg_s);
                                mag_b_s    = cneg32(B, b_neg_s);
                                neg_res_s  = a_neg_s ^ b_neg_s;
                                neg_rem_s  = a_neg_s;
                                div_zero_s = (B == 32'd0);
                                a_orig_s   = A;
                                rem_s      = 32'd0;
                                quo_s      = cneg32(A, a_neg_s);
                            end
                            OP_MTHI: hi_s = A;
                            OP_MTLO: lo_s = A;
                            default: state_s = ST_IDLE;
                        endcase
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == 5'd0) begin
                        state_s = ST_IDLE;
                        hi_s    = prod_s[63:32];
                        lo_s    = prod_s[31:0];
                    end else begin
                        cnt_s = cnt_r - 5'd1;
                    end
                end
                ST_DIV: begin
                    rem_s = rem_step_s;
                    quo_s = quo_step_s;
                    if (cnt_r == 5'd0) begin
                        state_s = ST_IDLE;
                        // Divide-by-zero still runs the full loop but returns fixed values.
                        if (div_zero_r) begin
                            lo_s = 32'hFFFF_FFFF;
                            hi_s = a_orig_r;
                        end else begin
                            lo_s = cneg32(quo_step_s, neg_res_r);
                            hi_s = cneg32(rem_step_s, neg_rem_r);
                        end
                    end else begin
                        cnt_s = cnt_r - 5'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 5'd0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            mag_a_r    <= 32'd0;
            mag_b_r    <= 32'd0;
            a_orig_r   <= 32'd0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            rem_r      <= 32'd0;
            quo_r      <= 32'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            mag_a_r    <= mag_a_s;
            mag_b_r    <= mag_b_s;
            a_orig_r   <= a_orig_s;
            neg_res_r  <= neg_res_s;
            neg_rem_r  <= neg_rem_s;
            div_zero_r <= div_zero_s;
            rem_r      <= rem_s;
            quo_r      <= quo_s;
        end
    end

    assign HI = hi_r;
    assign LO = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random traffic
// compared against an arithmetic reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  MDOp;
    logic        ex_adv;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        isbusy;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .rst(rst), .MDOp(MDOp), .ex_adv(ex_adv), .A(A), .B(B),
        .flush(flush), .HI(HI), .LO(LO), .isbusy(isbusy)
    );

    // Reference result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] ua, ub, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (op)
            3'b001: r = sa * sb;
            3'b010: r = ua * ub;
            3'b011: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'b100: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Issue one op for a single cycle, then count cycles until isbusy drops.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
        @(negedge clk);
        MDOp = op; A = a; B = b; ex_adv = 1'b1;
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
        cycles = 0;
        while (isbusy && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_adv = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", HI, 32'd0); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", LO, 32'd0); end
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", isbusy); end
        MDOp = 3'b001; A = 32'd7; B = 32'd9; ex_adv = 1'b1;
        #1;
        checks++; if (isbusy !== 1'b1) begin errors++; $display("FAIL reset_issue_term: got %b expected 1", isbusy); end
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        #1;
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b expected 0", isbusy); end
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult_vector();
        int cycles;
        @(negedge clk);
        MDOp = 3'b001; A = 32'hFFFF_FFFE; B = 32'd3; ex_adv = 1'b1;
        #1;
        checks++; if (isbusy !== 1'b1) begin errors++; $display("FAIL mult_issue_busy: got %b expected 1", isbusy); end
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        cycles = 0;
        while (isbusy && cycles < 100) begin @(negedge clk); cycles++; end
        checks++; if (cycles != 3) begin errors++; $display("FAIL mult_latency: got %0d expected 3", cycles); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    endtask

    task automatic test_div_vectors();
        logic [2:0]  ops [5] = '{3'b100, 3'b011, 3'b011, 3'b100, 3'b011};
        logic [31:0] as  [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_1234, 32'hFFFF_0000};
        logic [31:0] bs  [5] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] eh  [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'h0000_1234, 32'hFFFF_0000};
        logic [31:0] el  [5] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int cycles;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], cycles);
            checks++; if (cycles != 32) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 32", i, cycles); end
            checks++; if (HI !== eh[i]) begin errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, HI, eh[i]); end
            checks++; if (LO !== el[i]) begin errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, LO, el[i]); end
            m_hi = eh[i]; m_lo = el[i];
        end
    endtask

    task automatic test_flush();
        int cycles;
        do_op(3'b101, 32'h5A5A_5A5A, 32'd0, cycles);
        do_op(3'b110, 32'h5A5A_5A5A, 32'd0, cycles);
        @(negedge clk);
        MDOp = 3'b011; A = 32'd1000; B = 32'd3; ex_adv = 1'b1;
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", isbusy); end
        repeat (40) @(negedge clk);
        checks++; if (HI !== 32'h5A5A_5A5A) begin errors++; $display("FAIL flush_hi: got %h expected 5a5a5a5a", HI); end
        checks++; if (LO !== 32'h5A5A_5A5A) begin errors++; $display("FAIL flush_lo: got %h expected 5a5a5a5a", LO); end
        // Issue and MTHI coinciding with flush must be dropped.
        MDOp = 3'b001; A = 32'd3; B = 32'd3; ex_adv = 1'b1; flush = 1'b1;
        #1;
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL flush_issue_busy: got %b expected 0", isbusy); end
        @(negedge clk);
        MDOp = 3'b101; A = 32'h1357_9BDF;
        @(negedge clk);
        ex_adv = 1'b0; flush = 1'b0; MDOp = 3'd0;
        #1;
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b expected 0", isbusy); end
        checks++; if (HI !== 32'h5A5A_5A5A) begin errors++; $display("FAIL flush_mthi: got %h expected 5a5a5a5a", HI); end
        m_hi = 32'h5A5A_5A5A; m_lo = 32'h5A5A_5A5A;
    endtask

    task automatic test_busy_ignore();
        int cycles;
        @(negedge clk);
        MDOp = 3'b011; A = 32'd500; B = 32'd7; ex_adv = 1'b1;
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        repeat (5) @(negedge clk);
        MDOp = 3'b010; A = 32'd9; B = 32'd9; ex_adv = 1'b1;
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        cycles = 6;
        while (isbusy && cycles < 100) begin @(negedge clk); cycles++; end
        checks++; if (cycles != 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", cycles); end
        checks++; if (HI !== 32'd3) begin errors++; $display("FAIL ignore_hi: got %h expected %h", HI, 32'd3); end
        checks++; if (LO !== 32'd71) begin errors++; $display("FAIL ignore_lo: got %h expected %h", LO, 32'd71); end
        MDOp = 3'b110; A = 32'h0000_CAFE; ex_adv = 1'b1;
        #1;
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL mtlo_issue_busy: got %b expected 0", isbusy); end
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        checks++; if (LO !== 32'h0000_CAFE) begin errors++; $display("FAIL mtlo_lo: got %h expected 0000cafe", LO); end
        checks++; if (HI !== 32'd3) begin errors++; $display("FAIL mtlo_hi: got %h expected %h", HI, 32'd3); end
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", isbusy); end
        m_hi = 32'd3; m_lo = 32'h0000_CAFE;
    endtask

    task automatic test_reset_mid();
        int cycles;
        do_op(3'b101, 32'h1111_1111, 32'd0, cycles);
        do_op(3'b110, 32'h1111_1111, 32'd0, cycles);
        @(negedge clk);
        MDOp = 3'b001; A = 32'd5; B = 32'd6; ex_adv = 1'b1;
        @(negedge clk);
        ex_adv = 1'b0; MDOp = 3'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", HI, 32'd0); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", LO, 32'd0); end
        checks++; if (isbusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", isbusy); end
        repeat (4) @(negedge clk);
        checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL rstmid_late_write: got %h expected %h", {HI, LO}, 64'd0); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        int cycles, lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            do_op(op, a, b, cycles);
            if (op <= 3'b010) lat = 3;
            else if (op <= 3'b100) lat = 32;
            else lat = 0;
            if (op <= 3'b100) begin
                exp = ref_md(op, a, b);
                m_hi = exp[63:32];
                m_lo = exp[31:0];
            end else if (op == 3'b101) begin
                m_hi = a;
            end else begin
                m_lo = a;
            end
            checks++; if (cycles != lat) begin errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, op, cycles, lat); end
            checks++; if ({HI, LO} !== {m_hi, m_lo}) begin
                errors++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_vector();
        test_div_vectors();
        test_flush();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
